// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: Moore control decode from the state register,
// with fetch/branch write strobes gated combinationally by mem_ready/zero and async reset.
module multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrucao,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_ADDR = 4'd2,
        S_MEM_LOAD  = 4'd3,
        S_LOAD_WB   = 4'd4,
        S_MEM_STORE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_LUI       = 4'd10,
        S_AUIPC     = 4'd11,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    logic        bad_instr;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instrucao[6:0];
    assign funct3            = instrucao[14:12];
    assign unused_instr_bits = ^{instrucao[31:15], instrucao[11:7]};

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        bad_instr = 1'b0;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_EXEC_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           bad_instr = 1'b1;
                endcase
            end
            S_EXEC_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_STORE : S_MEM_LOAD;
            S_MEM_LOAD:  if (mem_ready) state_d = S_LOAD_WB;
            S_LOAD_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_STORE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_ALU_WB;
            S_ALU_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            // Only beq/bne are supported; other branch flavours are caught here.
            S_BRANCH: begin
                if (funct3[2:1] != 2'b00) begin
                    bad_instr = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase

        illegal_d = illegal_q | bad_instr;
        if (bad_instr) begin
            if (ILLEGAL_HALT) begin
                state_d = S_TRAP;
            end else begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
        end
        instret_d = instret_q + {31'd0, retire};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready & ~rst;
                pc_write  = mem_ready & ~rst;
            end
            S_DECODE: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b10;
            end
            S_EXEC_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEM_LOAD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_LOAD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_STORE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
            end
            S_ALU_WB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                case (funct3)
                    3'b000:  pc_write = zero;
                    3'b001:  pc_write = ~zero;
                    default: pc_write = 1'b0;
                endcase
            end
            S_LUI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_AUIPC: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b10;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a continuing DUT (ILLEGAL_HALT=0) and a halting DUT (=1) share stimulus.
module tb_multicycle_ctrl;

    localparam int FETCH = 0, DECODE = 1, EXEC_ADDR = 2, MEM_LOAD = 3, LOAD_WB = 4, MEM_STORE = 5;
    localparam int EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9, LUI = 10, AUIPC = 11, TRAP = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instrucao = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic a_i_or_d, a_mem_read, a_mem_write, a_ir_write, a_pc_write, a_pc_src, a_reg_write, a_mem_to_reg;
    logic [1:0] a_src_a, a_src_b, a_alu_op;
    logic [3:0] a_state;
    logic a_illegal;
    logic [31:0] a_instret;

    logic h_i_or_d, h_mem_read, h_mem_write, h_ir_write, h_pc_write, h_pc_src, h_reg_write, h_mem_to_reg;
    logic [1:0] h_src_a, h_src_b, h_alu_op;
    logic [3:0] h_state;
    logic h_illegal;
    logic [31:0] h_instret;

    logic [13:0] a_ctl, h_ctl;
    assign a_ctl = {a_i_or_d, a_mem_read, a_mem_write, a_ir_write, a_pc_write, a_pc_src,
                    a_reg_write, a_mem_to_reg, a_src_a, a_src_b, a_alu_op};
    assign h_ctl = {h_i_or_d, h_mem_read, h_mem_write, h_ir_write, h_pc_write, h_pc_src,
                    h_reg_write, h_mem_to_reg, h_src_a, h_src_b, h_alu_op};

    multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut (
        .clk(clk), .rst(rst), .instrucao(instrucao), .zero(zero), .mem_ready(mem_ready),
        .i_or_d(a_i_or_d), .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
        .pc_write(a_pc_write), .pc_src(a_pc_src), .reg_write(a_reg_write), .mem_to_reg(a_mem_to_reg),
        .alu_src_a(a_src_a), .alu_src_b(a_src_b), .alu_op(a_alu_op),
        .state(a_state), .illegal(a_illegal), .instret(a_instret)
    );

    multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (
        .clk(clk), .rst(rst), .instrucao(instrucao), .zero(zero), .mem_ready(mem_ready),
        .i_or_d(h_i_or_d), .mem_read(h_mem_read), .mem_write(h_mem_write), .ir_write(h_ir_write),
        .pc_write(h_pc_write), .pc_src(h_pc_src), .reg_write(h_reg_write), .mem_to_reg(h_mem_to_reg),
        .alu_src_a(h_src_a), .alu_src_b(h_src_b), .alu_op(h_alu_op),
        .state(h_state), .illegal(h_illegal), .instret(h_instret)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0, n_fail = 0;
    string cur_tag = "init";

    // Reference model: retired count and sticky illegal flag for each DUT.
    logic [31:0] m_ret = 32'd0, mh_ret = 32'd0;
    logic        m_ill = 1'b0, mh_ill = 1'b0, mh_trap = 1'b0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_tag, name, obs, exp);
        end
    endtask

    // Control outputs each state must show, straight from the state table.
    function automatic logic [13:0] exp_ctrl(input int st, input logic mr, input logic z, input logic [2:0] f3);
        logic iod = 0, mrd = 0, mw = 0, irw = 0, pcw = 0, pcs = 0, rw = 0, m2r = 0;
        logic [1:0] a = 2'b00, b = 2'b00, op = 2'b00;
        case (st)
            FETCH:     begin mrd = 1; irw = mr; pcw = mr; b = 2'b01; end
            DECODE:    begin a = 2'b11; b = 2'b10; end
            EXEC_ADDR: begin a = 2'b01; b = 2'b10; end
            MEM_LOAD:  begin iod = 1; mrd = 1; end
            LOAD_WB:   begin rw = 1; m2r = 1; end
            MEM_STORE: begin iod = 1; mw = 1; end
            EXEC_R:    begin a = 2'b01; op = 2'b10; end
            EXEC_I:    begin a = 2'b01; b = 2'b10; op = 2'b10; end
            ALU_WB:    rw = 1;
            BRANCH: begin
                a = 2'b01; op = 2'b01; pcs = 1;
                pcw = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? ~z : 1'b0);
            end
            LUI:       begin a = 2'b10; b = 2'b10; end
            AUIPC:     begin a = 2'b11; b = 2'b10; end
            default: ;
        endcase
        return {iod, mrd, mw, irw, pcw, pcs, rw, m2r, a, b, op};
    endfunction

    task automatic check_cycle(input int st, input logic [2:0] f3);
        #1;
        chk("state", 32'(a_state), 32'(st));
        chk("ctrl", 32'(a_ctl), 32'(exp_ctrl(st, mem_ready, zero, f3)));
        chk("instret", a_instret, m_ret);
        chk("illegal", 32'(a_illegal), 32'(m_ill));
        chk("h_state", 32'(h_state), mh_trap ? 32'(TRAP) : 32'(st));
        chk("h_ctrl", 32'(h_ctl), mh_trap ? 32'd0 : 32'(exp_ctrl(st, mem_ready, zero, f3)));
        chk("h_instret", h_instret, mh_ret);
        chk("h_illegal", 32'(h_illegal), 32'(mh_ill));
    endtask

    // Assert rst from a negedge; checks async effect, then holds over one edge.
    task automatic reset_and_check();
        rst = 1'b1;
        mem_ready = 1'b1;
        zero = 1'($urandom_range(0, 1));
        m_ret = 0; mh_ret = 0; m_ill = 0; mh_ill = 0; mh_trap = 0;
        #1;
        chk("rst_state", 32'(a_state), 32'(FETCH));
        chk("rst_ctrl", 32'(a_ctl), 32'(exp_ctrl(FETCH, 1'b0, 1'b0, 3'd0)));
        chk("rst_instret", a_instret, 32'd0);
        chk("rst_illegal", 32'(a_illegal), 32'd0);
        chk("rst_h_state", 32'(h_state), 32'(FETCH));
        chk("rst_h_ctrl", 32'(h_ctl), 32'(exp_ctrl(FETCH, 1'b0, 1'b0, 3'd0)));
        @(posedge clk);
        #1;
        chk("rst_hold_state", 32'(a_state), 32'(FETCH));
        chk("rst_hold_ctrl", 32'(a_ctl), 32'(exp_ctrl(FETCH, 1'b0, 1'b0, 3'd0)));
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    // One instruction from FETCH; stop_after>=0 abandons it before that cycle's edge.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic z,
                             input int wf, input int wm, input int stop_after);
        int q[$];
        logic [2:0] f3;
        bit bad;
        bit last_run;
        int st;
        cur_tag = tag;
        f3 = ins[14:12];
        bad = 0;
        for (int k = 0; k <= wf; k++) q.push_back(FETCH);
        q.push_back(DECODE);
        case (ins[6:0])
            7'b0000011: begin
                q.push_back(EXEC_ADDR);
                for (int k = 0; k <= wm; k++) q.push_back(MEM_LOAD);
                q.push_back(LOAD_WB);
            end
            7'b0100011: begin
                q.push_back(EXEC_ADDR);
                for (int k = 0; k <= wm; k++) q.push_back(MEM_STORE);
            end
            7'b0110011: begin q.push_back(EXEC_R); q.push_back(ALU_WB); end
            7'b0010011: begin q.push_back(EXEC_I); q.push_back(ALU_WB); end
            7'b0110111: begin q.push_back(LUI);    q.push_back(ALU_WB); end
            7'b0010111: begin q.push_back(AUIPC);  q.push_back(ALU_WB); end
            7'b1100011: begin q.push_back(BRANCH); bad = (f3 > 3'd1); end
            default:    bad = 1;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            st = q[i];
            last_run = (i == q.size() - 1) || (q[i+1] != st);
            if (st == FETCH || st == MEM_LOAD || st == MEM_STORE) mem_ready = last_run;
            else mem_ready = 1'($urandom_range(0, 1));
            zero = (st == BRANCH) ? z : 1'($urandom_range(0, 1));
            instrucao = (st == FETCH) ? $urandom : ins;
            check_cycle(st, f3);
            if (stop_after >= 0 && i == stop_after) return;
            @(posedge clk);
            @(negedge clk);
        end
        m_ret = m_ret + 32'd1;
        if (bad) m_ill = 1'b1;
        if (!mh_trap) begin
            if (bad) begin
                mh_trap = 1'b1;
                mh_ill  = 1'b1;
            end else begin
                mh_ret = mh_ret + 32'd1;
            end
        end
    endtask

    logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1111111};

    initial begin
        logic [31:0] r;
        #2;
        @(negedge clk);
        cur_tag = "reset";
        reset_and_check();

        run_instr("addi",    32'h00500093, 1'b0, 0, 0, -1);
        run_instr("lw_wait", 32'h0000A083, 1'b0, 1, 3, -1);
        run_instr("beq_z1",  32'h00208463, 1'b1, 0, 0, -1);
        run_instr("beq_z0",  32'h00208463, 1'b0, 0, 0, -1);
        run_instr("bne_z0",  32'h00209463, 1'b0, 0, 0, -1);
        run_instr("sw",      32'h0020A023, 1'b0, 2, 2, -1);
        run_instr("lui",     32'h000010B7, 1'b0, 0, 0, -1);
        run_instr("auipc",   32'h00001097, 1'b0, 0, 0, -1);
        run_instr("add",     32'h002080B3, 1'b0, 0, 0, -1);
        run_instr("ill_7f",  32'h0000007F, 1'b0, 0, 0, -1);
        run_instr("post_ill", 32'h00500093, 1'b0, 0, 0, -1);

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 7)];
            run_instr("rand", r, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
        end

        // Reset lands in the second MEM_STORE wait cycle.
        run_instr("sw_abort", 32'h0020A023, 1'b0, 0, 3, 4);
        cur_tag = "rst_mid_store";
        reset_and_check();

        run_instr("bad_branch", 32'h0020A463, 1'b1, 0, 0, -1);
        run_instr("after_bad",  32'h00500093, 1'b0, 0, 0, -1);

        cur_tag = "wrap";
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        m_ret = 32'hFFFF_FFFF;
        run_instr("lui_wrap", 32'h123450B7, 1'b0, 0, 0, -1);
        run_instr("after_wrap", 32'h00500093, 1'b0, 1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: ILLEGAL_HALT, 1, 1 = illegal instruction enters TRAP permanently; 0 = illegal instruction retires as NOP.
REQ-002 SHALL use one clock; reset is asynchronous and active-high: clk input 1 (rising edge), rst input 1.
REQ-003 SHALL have port: instrucao input 32, IR contents, valid from DECODE onward.
REQ-004 SHALL have port: zero input 1, ALU zero flag, sampled in BRANCH.
REQ-005 SHALL have port: mem_ready input 1, memory access complete this cycle.
REQ-006 SHALL have ports, all outputs 1: i_or_d (0 = PC address, 1 = ALUOut address), mem_read, mem_write, ir_write, pc_write, pc_src (0 = ALU result, 1 = ALUOut target), reg_write, mem_to_reg.
REQ-007 SHALL have ports, all outputs 2: alu_src_a (00 PC, 01 rs1, 10 const 0, 11 oldPC); alu_src_b (00 rs2, 01 const 4, 10 immediate); alu_op (00 add, 01 subtract/compare, 10 funct-decoded).
REQ-008 SHALL have ports: state output 4, current state encoding; illegal output 1, sticky illegal flag; instret output 32, retired-instruction count.

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, EXEC_ADDR=2, MEM_LOAD=3, LOAD_WB=4, MEM_STORE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, LUI=10, AUIPC=11, TRAP=15; unused codes SHALL go to TRAP on the next edge.
REQ-010 SHALL deassert, or set to 00, every control output not listed for the current state.
REQ-011 FETCH: i_or_d=0, mem_read=1, alu_src_a=00, alu_src_b=01, alu_op=00.
REQ-012 FETCH: ir_write and pc_write SHALL be combinational with mem_ready, asserted only in the mem_ready cycle; the next state is DECODE if mem_ready=1, otherwise FETCH, with mem_read held.
REQ-013 DECODE: alu_src_a=11, alu_src_b=10, alu_op=00, computing the branch target into ALUOut.
REQ-014 DECODE next state by opcode: 0000011 -> EXEC_ADDR; 0100011 -> EXEC_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 0110111 -> LUI; 0010111 -> AUIPC; any other opcode is illegal.
REQ-015 EXEC_ADDR: a=01, b=10, op=00; next state MEM_LOAD for a load, MEM_STORE for a store.
REQ-016 MEM_LOAD: i_or_d=1, mem_read=1 held until mem_ready; then LOAD_WB.
REQ-017 LOAD_WB: reg_write=1, mem_to_reg=1; next state FETCH.
REQ-018 MEM_STORE: i_or_d=1, mem_write=1 held until mem_ready; then FETCH.
REQ-019 EXEC_R: a=01, b=00, op=10; EXEC_I: a=01, b=10, op=10; LUI: a=10, b=10, op=00; AUIPC: a=11, b=10, op=00; all four then go to ALU_WB.
REQ-020 ALU_WB: reg_write=1, mem_to_reg=0; next state FETCH.
REQ-021 BRANCH: a=01, b=00, op=01, pc_src=1; pc_write=zero when funct3=000, pc_write=~zero when funct3=001; next state FETCH.
REQ-022 BRANCH with any other funct3 is illegal.
REQ-023 Illegal instruction: illegal SHALL be set on the next edge.
REQ-024 Illegal instruction: next state is TRAP if ILLEGAL_HALT=1, otherwise FETCH with instret incremented.
REQ-025 TRAP: all control outputs 0; SHALL remain in TRAP until rst.
REQ-026 instret SHALL increment by 1 on each retiring transition: LOAD_WB->FETCH, MEM_STORE->FETCH with mem_ready, ALU_WB->FETCH, BRANCH->FETCH, illegal NOP.
REQ-027 instret SHALL wrap 0xFFFFFFFF -> 0.
REQ-028 mem_ready SHALL be ignored outside FETCH, MEM_LOAD and MEM_STORE.

Reset
REQ-029 rst=1 SHALL immediately force state=FETCH, illegal=0, instret=0, without waiting for clk.
REQ-030 While rst=1, all control outputs other than the FETCH Moore values SHALL be 0; ir_write and pc_write SHALL be 0 regardless of mem_ready.
REQ-031 rst asserted mid-MEM_LOAD or mid-MEM_STORE SHALL drop mem_read/mem_write in the same cycle; no partial write is flagged.

Verification
REQ-032 addi x1,x0,5 (0x00500093), mem_ready=1 in fetch -> state 0,1,7,8,0; reg_write=1 only in ALU_WB; instret 0->1.
REQ-033 lw (0x0000A083) with mem_ready low 3 cycles in MEM_LOAD -> mem_read and i_or_d held 4 cycles; LOAD_WB has mem_to_reg=1; instret=1.
REQ-034 beq (0x00208463): zero=1 -> pc_write=1, pc_src=1 in BRANCH; zero=0 -> pc_write=0; both return to FETCH.
REQ-035 Opcode 0x7F with ILLEGAL_HALT=1 -> TRAP, illegal=1 and stuck; with ILLEGAL_HALT=0 -> FETCH, instret +1.
REQ-036 rst pulse during MEM_STORE -> mem_write=0 combinationally, state=0, instret=0.
REQ-037 Preload instret to 0xFFFFFFFF via 2^32-1 retirements, or force in simulation -> next lui retires, instret=0.
